// File: rtl/i2c_reg_sequencer_if.sv
// Bundle between the register sequencer, its command source and the I2C byte master.
// cmd: transfer when cmd_valid && cmd_ready; rsp_valid is a one-cycle pulse with no back-pressure.
interface i2c_reg_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_rw;
  logic [7:0] cmd_reg;
  logic [7:0] cmd_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic [6:0] m_address;
  logic [7:0] m_register;
  logic       m_mode;
  logic       m_en;
  logic       m_start;
  logic       m_stop;
  logic       m_repeat_start;
  logic       m_ack;
  logic [7:0] m_out;

  modport slave (
    input  cmd_valid, cmd_rw, cmd_reg, cmd_wdata, m_ack, m_out,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           m_address, m_register, m_mode, m_en, m_start, m_stop, m_repeat_start
  );

  modport master (
    output cmd_valid, cmd_rw, cmd_reg, cmd_wdata, m_ack, m_out,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
           m_address, m_register, m_mode, m_en, m_start, m_stop, m_repeat_start
  );
endinterface

// File: rtl/i2c_reg_sequencer.sv
// Single-register write/read sequencer driving an I2C byte master; advances on the
// master's per-byte ack pulses and aborts with rsp_err when an ack takes too long.
module i2c_reg_sequencer #(
  parameter logic [6:0]  DEV_ADDR = 7'h50,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic                      sys_clk,
  input  logic                      reset,
  i2c_reg_sequencer_if.slave        bus,
  output logic [2:0]                dbg_state_o
);

  typedef enum logic [2:0] {
    IDLE, W_ADDR, W_PTR, W_DATA, R_RS, R_ADDR, R_DATA, DONE
  } state_e;

  localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       rw_q, rw_d;
  logic [7:0] wdata_q, wdata_d;
  logic       rd_pend_q, rd_pend_d;
  logic       cmd_ready_q, cmd_ready_d;
  logic       rsp_valid_q, rsp_valid_d;
  logic       rsp_err_q, rsp_err_d;
  logic [7:0] rsp_rdata_q, rsp_rdata_d;
  logic [7:0] m_register_q, m_register_d;
  logic       m_mode_q, m_mode_d;
  logic       m_en_q, m_en_d;
  logic       m_start_q, m_start_d;
  logic       m_stop_q, m_stop_d;
  logic       m_rs_q, m_rs_d;
  logic       waiting;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rw_d         = rw_q;
    wdata_d      = wdata_q;
    rd_pend_d    = rd_pend_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    m_register_d = m_register_q;
    m_mode_d     = m_mode_q;
    m_en_d       = m_en_q;
    m_start_d    = m_start_q;
    m_stop_d     = m_stop_q;
    m_rs_d       = m_rs_q;
    waiting      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.cmd_valid && cmd_ready_q) begin
          rw_d         = bus.cmd_rw;
          wdata_d      = bus.cmd_wdata;
          m_register_d = bus.cmd_reg;
          m_mode_d     = 1'b0;
          m_en_d       = 1'b1;
          m_start_d    = 1'b1;
          cnt_d        = 8'd0;
          rd_pend_d    = 1'b0;
          state_d      = W_ADDR;
        end
      end
      W_ADDR: begin
        waiting = 1'b1;
        if (bus.m_ack) begin
          m_start_d = 1'b0;
          state_d   = W_PTR;
        end
      end
      W_PTR: begin
        waiting = 1'b1;
        if (bus.m_ack) begin
          if (rw_q) begin
            m_rs_d   = 1'b1;
            m_mode_d = 1'b1;
            state_d  = R_RS;
          end else begin
            m_register_d = wdata_q;
            m_stop_d     = 1'b1;
            state_d      = W_DATA;
          end
        end
      end
      W_DATA: begin
        waiting = 1'b1;
        if (bus.m_ack) begin
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      R_RS: begin
        waiting = 1'b1;
        if (bus.m_ack) begin
          m_rs_d   = 1'b0;
          m_stop_d = 1'b1;
          state_d  = R_DATA;
        end
      end
      R_DATA: begin
        // The master's output byte settles one cycle after its final ack.
        if (rd_pend_q) begin
          rd_pend_d   = 1'b0;
          rsp_rdata_d = bus.m_out;
          rsp_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          waiting = 1'b1;
          if (bus.m_ack) rd_pend_d = 1'b1;
        end
      end
      DONE: begin
        m_en_d    = 1'b0;
        m_start_d = 1'b0;
        m_stop_d  = 1'b0;
        m_rs_d    = 1'b0;
        cnt_d     = 8'd0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // An ack in the same cycle as expiry takes priority over the abort.
    if (waiting) begin
      if (bus.m_ack) begin
        cnt_d = 8'd0;
      end else begin
        cnt_d = cnt_q + 8'd1;
        if (cnt_d == TIMEOUT_C) begin
          m_stop_d    = 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b1;
          rd_pend_d   = 1'b0;
          state_d     = DONE;
        end
      end
    end

    cmd_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 8'd0;
      rw_q         <= 1'b0;
      wdata_q      <= 8'h00;
      rd_pend_q    <= 1'b0;
      cmd_ready_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_rdata_q  <= 8'h00;
      m_register_q <= 8'h00;
      m_mode_q     <= 1'b0;
      m_en_q       <= 1'b0;
      m_start_q    <= 1'b0;
      m_stop_q     <= 1'b0;
      m_rs_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rw_q         <= rw_d;
      wdata_q      <= wdata_d;
      rd_pend_q    <= rd_pend_d;
      cmd_ready_q  <= cmd_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_rdata_q  <= rsp_rdata_d;
      m_register_q <= m_register_d;
      m_mode_q     <= m_mode_d;
      m_en_q       <= m_en_d;
      m_start_q    <= m_start_d;
      m_stop_q     <= m_stop_d;
      m_rs_q       <= m_rs_d;
    end
  end

  assign bus.cmd_ready      = cmd_ready_q;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_err        = rsp_err_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign bus.m_address      = DEV_ADDR;
  assign bus.m_register     = m_register_q;
  assign bus.m_mode         = m_mode_q;
  assign bus.m_en           = m_en_q;
  assign bus.m_start        = m_start_q;
  assign bus.m_stop         = m_stop_q;
  assign bus.m_repeat_start = m_rs_q;
  assign dbg_state_o        = state_q;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: ack-count reference model compared every cycle,
// response scoreboard, directed scenarios and randomized ack spacing.
module tb_i2c_reg_sequencer;
  localparam int         TO  = 16;
  localparam logic [6:0] DEV = 7'h50;

  logic       sys_clk = 1'b0;
  logic       reset   = 1'b1;
  logic [2:0] dbg_state;
  int         checks  = 0;
  int         errors  = 0;
  int         rsp_seen = 0;

  i2c_reg_sequencer_if ifc();

  i2c_reg_sequencer #(.DEV_ADDR(DEV), .TIMEOUT(TO)) dut (
    .sys_clk     (sys_clk),
    .reset       (reset),
    .bus         (ifc.slave),
    .dbg_state_o (dbg_state)
  );

  always #5 sys_clk = ~sys_clk;

  // ---------------- reference model (transaction phase + ack count) ----------------
  logic       e_ready, e_rv, e_err, e_mode, e_en, e_start, e_stop, e_rs;
  logic [7:0] e_rdata, e_reg;
  int         ph;          // 0 idle, 1 busy, 2 reporting
  int         acks, waitc;
  logic       pend, l_rw;
  logic [7:0] l_wd;
  logic [8:0] exp_q[$];    // {err, rdata} per completed command

  task model_reset();
    e_ready = 0; e_rv = 0; e_err = 0; e_mode = 0; e_en = 0; e_start = 0;
    e_stop = 0; e_rs = 0; e_rdata = 8'h00; e_reg = 8'h00;
    ph = 0; acks = 0; waitc = 0; pend = 0; l_rw = 0; l_wd = 8'h00;
  endtask

  task model_finish(input logic err);
    e_rv = 1; e_err = err; ph = 2;
    exp_q.push_back({err, e_rdata});
  endtask

  task model_step();
    if (reset) begin
      model_reset();
      exp_q.delete();
    end else begin
      e_rv = 0; e_err = 0;
      if (ph == 0) begin
        if (ifc.cmd_valid && e_ready) begin
          l_rw = ifc.cmd_rw; l_wd = ifc.cmd_wdata; e_reg = ifc.cmd_reg;
          e_en = 1; e_start = 1; e_mode = 0;
          ph = 1; acks = 0; waitc = 0; pend = 0;
        end
      end else if (ph == 1) begin
        if (pend) begin
          e_rdata = ifc.m_out;
          model_finish(1'b0);
        end else if (ifc.m_ack) begin
          acks++; waitc = 0;
          if (acks == 1) e_start = 0;
          else if (acks == 2 && !l_rw) begin e_reg = l_wd; e_stop = 1; end
          else if (acks == 2 && l_rw) begin e_rs = 1; e_mode = 1; end
          else if (acks == 3 && !l_rw) model_finish(1'b0);
          else if (acks == 3 && l_rw) begin e_rs = 0; e_stop = 1; end
          else if (acks == 4) pend = 1;
        end else begin
          waitc++;
          if (waitc == TO) begin e_stop = 1; model_finish(1'b1); end
        end
      end else begin
        e_en = 0; e_start = 0; e_stop = 0; e_rs = 0; ph = 0;
      end
      e_ready = (ph == 0);
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk);
      model_step();
    end
  end

  // ---------------- per-cycle compare + response scoreboard ----------------
  function automatic logic [30:0] act_vec();
    return {ifc.cmd_ready, ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata, ifc.m_address,
            ifc.m_register, ifc.m_mode, ifc.m_en, ifc.m_start, ifc.m_stop, ifc.m_repeat_start};
  endfunction

  function automatic logic [30:0] exp_vec();
    return {e_ready, e_rv, e_err, e_rdata, DEV, e_reg, e_mode, e_en, e_start, e_stop, e_rs};
  endfunction

  initial begin
    logic [8:0] r;
    @(posedge sys_clk);
    forever begin
      @(negedge sys_clk);
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t got=%h want=%h state=%0d", $time, act_vec(), exp_vec(), dbg_state);
      end
      if (ifc.rsp_valid === 1'b1) begin
        rsp_seen++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL rsp_unexpected got={%b,%h} want=none", ifc.rsp_err, ifc.rsp_rdata);
        end else begin
          r = exp_q.pop_front();
          if ({ifc.rsp_err, ifc.rsp_rdata} !== r) begin
            errors++;
            $display("FAIL rsp_payload got={%b,%h} want={%b,%h}", ifc.rsp_err, ifc.rsp_rdata, r[8], r[7:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task wait_ready();
    int n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 60) begin cycle(); n++; end
    chk("ready_wait", 32'(ifc.cmd_ready), 32'd1);
  endtask

  task issue(input logic rw, input logic [7:0] rg, input logic [7:0] wd);
    wait_ready();
    ifc.cmd_valid = 1; ifc.cmd_rw = rw; ifc.cmd_reg = rg; ifc.cmd_wdata = wd;
    cycle();
    ifc.cmd_valid = 0;
  endtask

  task ack(input int gap);
    repeat (gap - 1) cycle();
    ifc.m_ack = 1;
    cycle();
    ifc.m_ack = 0;
  endtask

  task wait_rsp(output int n);
    n = 0;
    while (ifc.rsp_valid !== 1'b1 && n < 60) begin cycle(); n++; end
    chk("rsp_wait", 32'(ifc.rsp_valid), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int n, base;
    logic rw;
    ifc.cmd_valid = 0; ifc.cmd_rw = 0; ifc.cmd_reg = 0; ifc.cmd_wdata = 0;
    ifc.m_ack = 0; ifc.m_out = 0;
    repeat (3) cycle();
    chk("reset_ready", 32'(ifc.cmd_ready), 32'd0);
    chk("reset_en", 32'(ifc.m_en), 32'd0);
    reset = 0;
    cycle();
    chk("ready_after_reset", 32'(ifc.cmd_ready), 32'd1);
    chk("reset_rdata", 32'(ifc.rsp_rdata), 32'h00);

    // directed register write
    issue(1'b0, 8'h3C, 8'hA5);
    chk("wr_start", 32'({ifc.m_en, ifc.m_start}), 32'b11);
    chk("wr_reg0", 32'(ifc.m_register), 32'h3C);
    chk("wr_addr", 32'(ifc.m_address), 32'h50);
    ack(10);
    chk("wr_start_drop", 32'({ifc.m_start, ifc.m_stop}), 32'b00);
    ack(10);
    chk("wr_reg1", 32'(ifc.m_register), 32'hA5);
    chk("wr_stop", 32'({ifc.m_stop, ifc.m_mode}), 32'b10);
    ack(10);
    chk("wr_rsp", 32'({ifc.rsp_valid, ifc.rsp_err}), 32'b10);
    cycle();
    chk("wr_ready_back", 32'({ifc.cmd_ready, ifc.rsp_valid, ifc.m_en}), 32'b100);

    // directed register read
    ifc.m_out = 8'h5A;
    issue(1'b1, 8'h10, 8'h00);
    ack(5); ack(5);
    chk("rd_rs", 32'({ifc.m_repeat_start, ifc.m_mode, ifc.m_stop}), 32'b110);
    ack(5);
    chk("rd_stop", 32'({ifc.m_repeat_start, ifc.m_stop}), 32'b01);
    ack(5);
    chk("rd_no_rsp_yet", 32'(ifc.rsp_valid), 32'd0);
    cycle();
    chk("rd_rsp", 32'({ifc.rsp_valid, ifc.rsp_err, ifc.rsp_rdata}), {22'd0, 2'b10, 8'h5A});
    cycle();

    // timeout with no acks
    issue(1'b0, 8'h22, 8'h33);
    wait_rsp(n);
    chk("to_cycles", 32'(n), 32'd16);
    chk("to_flags", 32'({ifc.rsp_err, ifc.m_stop}), 32'b11);
    chk("to_rdata_kept", 32'(ifc.rsp_rdata), 32'h5A);
    cycle();

    // command held while busy is ignored, then accepted afterwards
    base = rsp_seen;
    wait_ready();
    ifc.cmd_valid = 1; ifc.cmd_rw = 0; ifc.cmd_reg = 8'h41; ifc.cmd_wdata = 8'h99;
    cycle();
    ifc.cmd_rw = 1; ifc.cmd_reg = 8'h77;
    ack(3);
    chk("busy_reg_kept", 32'(ifc.m_register), 32'h41);
    ack(3); ack(3);
    chk("busy_wr_done", 32'(ifc.rsp_valid), 32'd1);
    n = 0;
    while (ifc.cmd_ready !== 1'b1 && n < 10) begin cycle(); n++; end
    cycle();
    ifc.cmd_valid = 0;
    ifc.m_out = 8'hC3;
    ack(2); ack(2); ack(2); ack(2);
    wait_rsp(n);
    chk("busy_rd_data", 32'(ifc.rsp_rdata), 32'hC3);
    cycle();
    chk("busy_rsp_count", 32'(rsp_seen - base), 32'd2);

    // reset while waiting in the read-data phase
    base = rsp_seen;
    issue(1'b1, 8'h20, 8'h00);
    ack(4); ack(4); ack(4);
    reset = 1;
    cycle();
    chk("mid_reset_outs", 32'(act_vec()), 32'({1'b0, 1'b0, 1'b0, 8'h00, DEV, 8'h00, 5'b00000}));
    reset = 0;
    cycle();
    chk("mid_reset_ready", 32'(ifc.cmd_ready), 32'd1);
    chk("mid_reset_no_rsp", 32'(rsp_seen - base), 32'd0);
    issue(1'b0, 8'h01, 8'h02);
    ack(3); ack(3); ack(3);
    chk("post_reset_wr", 32'({ifc.rsp_valid, ifc.rsp_err}), 32'b10);
    cycle();

    // stray acks in idle
    repeat (3) begin
      ack(2);
      chk("stray_ack_idle", 32'({ifc.cmd_ready, ifc.m_en}), 32'b10);
    end

    // randomized commands and ack spacing (some gaps reach the timeout)
    repeat (40) begin
      rw = 1'($urandom_range(0, 1));
      ifc.m_out = 8'($urandom);
      issue(rw, 8'($urandom), 8'($urandom));
      for (int i = 0; i < (rw ? 4 : 3); i++) ack($urandom_range(1, 18));
      repeat (3) cycle();
      if ($urandom_range(0, 3) == 0) ack($urandom_range(1, 3));
    end
    repeat (4) cycle();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/i2c_reg_sequencer.md
# i2c_reg_sequencer

Register-level transaction sequencer that sits directly upstream of the I2C byte master and drives its address, register, mode, enable and Start/Stop/repeat-start controls. It accepts one command at a time: either write one byte to a device register, or read one byte from a device register using a pointer-write, repeated-start and read sequence. It counts the master's per-byte ack pulses to advance, captures read data from the master's output byte, and aborts with an error flag if an ack does not arrive within a timeout.

## Interface
- DEV_ADDR, 7'h50, 7-bit target device address driven on m_address.
- TIMEOUT, 255, maximum sys_clk cycles spent waiting for any single m_ack before aborting; 1..255.
- sys_clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command request; transfer occurs when cmd_valid && cmd_ready.
- cmd_ready  out  1  high only in IDLE.
- cmd_rw  in  1  0 = register write, 1 = register read.
- cmd_reg  in  8  device register (pointer) byte.
- cmd_wdata  in  8  write data; ignored for reads.
- rsp_valid  out  1  one-cycle pulse when a command completes or aborts.
- rsp_rdata  out  8  read data; valid with rsp_valid for reads; holds its last value otherwise.
- rsp_err  out  1  valid with rsp_valid; 1 = timeout abort.
- m_address  out  7  to the master; constant DEV_ADDR.
- m_register  out  8  byte the master transmits next.
- m_mode  out  1  to the master; 0 = write, 1 = read.
- m_en, m_start, m_stop, m_repeat_start  out  1 each  master controls.
- m_ack  in  1  one-cycle pulse from the master at each byte ack phase.
- m_out  in  8  byte the master received.

## Operation
- Reset values: cmd_ready 0 during reset and 1 in the first cycle after; rsp_valid 0; rsp_err 0; rsp_rdata 8'h00; m_register 8'h00; m_mode 0; m_en, m_start, m_stop and m_repeat_start 0; state IDLE; timeout counter 0.
- All outputs are registered. The command fields are latched at acceptance.
- States: IDLE, W_ADDR, W_PTR, W_DATA, R_RS, R_ADDR, R_DATA, DONE.
- IDLE: on acceptance, set m_en=1, m_start=1, m_mode=0 and m_register=cmd_reg, then go to W_ADDR.
- W_ADDR: on m_ack (address acked), drop m_start and go to W_PTR.
- W_PTR (write): on m_ack (pointer acked), set m_register=cmd_wdata and m_stop=1, then go to W_DATA.
- W_PTR (read): on m_ack, set m_repeat_start=1 and m_mode=1, then go to R_RS.
- W_DATA: on m_ack, go to DONE with err=0.
- R_RS: on the next m_ack (repeated address acked), drop m_repeat_start, set m_stop=1 and go to R_DATA.
- R_DATA: on m_ack, wait one cycle, then capture m_out into rsp_rdata and go to DONE with err=0.
- DONE: pulse rsp_valid for one cycle with rsp_err. Clear m_en, m_start, m_stop and m_repeat_start. Return to IDLE.
- Timeout: the counter clears on entry to each wait state and on every m_ack, and increments otherwise. If it reaches TIMEOUT in any wait state, set m_stop=1, go to DONE with err=1, and leave rsp_rdata unchanged.
- m_ack in IDLE or DONE is ignored.
- cmd_valid while busy is ignored; the command is not queued.
- If m_ack and timeout expiry fall in the same cycle, m_ack wins.
- Reset mid-command: all outputs return to their reset values at the next edge. The command is dropped with no rsp_valid.

## Timing
- Accept edge → m_en and m_start high on the next cycle.
- m_ack edge → next state and updated m_* outputs one cycle later.
- Read data is sampled from m_out 2 cycles after the final m_ack. rsp_valid follows in that same cycle.
- Write completes 1 cycle after the third m_ack, with rsp_valid high for that 1 cycle.
- cmd_ready returns high 1 cycle after rsp_valid.
- Minimum command spacing: 1 idle cycle between rsp_valid and the next acceptance.

## Test plan
- Write reg 8'h3C with data 8'hA5, model acks at +20, +40 and +60 cycles → m_register goes 8'h3C then 8'hA5; m_stop rises after the 2nd ack; rsp_valid at 3rd ack +1 with err=0; m_mode stays 0.
- Read reg 8'h10, model returns m_out=8'h5A, 4 acks → m_repeat_start and m_mode=1 after the 2nd ack; m_stop after the 3rd; rsp_rdata=8'h5A and err=0 at 4th ack +2.
- No ack after start with TIMEOUT=16 → rsp_valid with err=1 exactly 16 cycles after entering W_ADDR; m_stop=1 before DONE; rsp_rdata unchanged.
- cmd_valid held high with a new command during a busy write → second command ignored; accepted only after cmd_ready returns; two rsp_valid pulses in total.
- Assert reset in R_DATA → all outputs at reset values next edge; no rsp_valid; a following write completes normally.
- Stray m_ack pulses in IDLE → no state change; cmd_ready stays 1.
